// File: rtl/branch_predict_btb.sv
// Direct-mapped BTB with 2-bit direction counters; zero-latency lookup, single-edge update, no backpressure.
// Optional statistics counters are built when BTB_STATS_EN is defined.
module branch_predict_btb #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              upd_mispredict,
  input  logic              flush_all
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_mispredicts
`endif
);

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];

  logic [IDX_W-1:0]  lk_idx, upd_idx;
  logic [TAG_W-1:0]  lk_tag, upd_tag;
  logic              upd_hit;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

  assign lk_hit    = reset && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken  = lk_hit && ctr_q[lk_idx][1];
  assign lk_target = lk_taken ? tgt_q[lk_idx] : lk_pc + ADDR_W'(4);

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign upd_mispredict = reset && upd_valid &&
                          ((upd_taken != upd_pred_taken) ||
                           (upd_taken && (upd_pred_target != upd_target)));

  // flush_all outranks a same-cycle update; counters and targets survive a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
          tgt_q[upd_idx] <= upd_target;
        end else begin
          if (ctr_q[upd_idx] != 2'b00) ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx] <= 1'b1;
        tag_q[upd_idx]   <= upd_tag;
        tgt_q[upd_idx]   <= upd_target;
        ctr_q[upd_idx]   <= 2'b10;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_lookups     <= '0;
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (upd_valid)                   stat_updates     <= stat_updates + 32'd1;
      if (upd_valid && upd_pred_taken) stat_lookups     <= stat_lookups + 32'd1;
      if (upd_mispredict)              stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_btb.sv
// Directed bench for branch_predict_btb (ENTRIES=16); stats checked when BTB_STATS_EN is defined.
module tb_branch_predict_btb;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lk_pc;
  logic        lk_hit, lk_taken;
  logic [31:0] lk_target;
  logic        upd_valid;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        upd_taken, upd_pred_taken;
  logic        upd_mispredict;
  logic        flush_all;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_updates, stat_mispredicts;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_lk = 0, exp_upd = 0, exp_mis = 0;

  branch_predict_btb #(.ADDR_W(32), .ENTRIES(16)) dut (
    .clk(clk), .reset(reset),
    .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_target(lk_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .upd_mispredict(upd_mispredict),
    .flush_all(flush_all)
`ifdef BTB_STATS_EN
    , .stat_lookups(stat_lookups), .stat_updates(stat_updates),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic look(input logic [31:0] pc, input logic hit, input logic tk,
                      input logic [31:0] tgt, input string tag);
    lk_pc = pc;
    #1;
    check({tag, ".hit"}, {31'd0, lk_hit}, {31'd0, hit});
    check({tag, ".taken"}, {31'd0, lk_taken}, {31'd0, tk});
    check({tag, ".target"}, lk_target, tgt);
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = pt; upd_pred_target = ptgt;
  endtask

  // One clock edge; statistics expectations follow the driven values.
  task automatic tick();
    if (reset && upd_valid) begin
      exp_upd++;
      if (upd_pred_taken) exp_lk++;
      if ((upd_taken != upd_pred_taken) || (upd_taken && upd_pred_target != upd_target)) exp_mis++;
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    flush_all = 1'b0;
    @(negedge clk);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptgt);
    drive_upd(pc, tk, tgt, pt, ptgt);
    tick();
  endtask

  initial begin
    reset = 1'b0; lk_pc = 32'h40; flush_all = 1'b0;
    drive_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    #12;
    check("rst.mispredict_masked", {31'd0, upd_mispredict}, 32'd0);
    upd_valid = 1'b0;
    look(32'h40, 1'b0, 1'b0, 32'h44, "rst");
`ifdef BTB_STATS_EN
    check("rst.stat_updates", stat_updates, 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);

    // Allocation on a taken miss
    drive_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    #1;
    check("alloc.mispredict", {31'd0, upd_mispredict}, 32'd1);
    tick();
    look(32'h40, 1'b1, 1'b1, 32'h100, "alloc");

    // Saturate up: 10 -> 11 and stays
    drive_upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    #1;
    check("correct.mispredict", {31'd0, upd_mispredict}, 32'd0);
    tick();
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    look(32'h40, 1'b1, 1'b1, 32'h100, "sat_hi_nt1");
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    look(32'h40, 1'b1, 1'b0, 32'h44, "sat_hi_nt2");

    // Saturate down at 00, then climb back: 00 -> 01 -> 10
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 32'h200, 1'b0, 32'h44);
    look(32'h40, 1'b1, 1'b0, 32'h44, "sat_lo_t1");
    upd(32'h40, 1'b1, 32'h200, 1'b0, 32'h44);
    look(32'h40, 1'b1, 1'b1, 32'h200, "sat_lo_t2");

    // Not-taken miss on a conflicting tag writes nothing
    upd(32'h1040, 1'b0, 32'h0, 1'b0, 32'h1044);
    look(32'h40, 1'b1, 1'b1, 32'h200, "miss_nt.keep");
    look(32'h1040, 1'b0, 1'b0, 32'h1044, "miss_nt.probe");

    // Conflict eviction at index 0
    upd(32'h80, 1'b1, 32'h300, 1'b0, 32'h84);
    look(32'h40, 1'b0, 1'b0, 32'h44, "conflict.old");
    look(32'h80, 1'b1, 1'b1, 32'h300, "conflict.new");
    look(32'h44, 1'b0, 1'b0, 32'h48, "conflict.other_idx");

    // Combinational mispredict on target mismatch / agreeing not-taken
    drive_upd(32'h80, 1'b1, 32'h300, 1'b1, 32'h999);
    #1;
    check("mis.target", {31'd0, upd_mispredict}, 32'd1);
    drive_upd(32'h80, 1'b0, 32'h300, 1'b0, 32'h999);
    #1;
    check("mis.nt_agree", {31'd0, upd_mispredict}, 32'd0);
    upd_valid = 1'b0;
    #1;
    check("mis.idle", {31'd0, upd_mispredict}, 32'd0);

    // Flush, then same-cycle lookup/allocation
    flush_all = 1'b1;
    tick();
    look(32'h80, 1'b0, 1'b0, 32'h84, "flush");
    lk_pc = 32'h40;
    drive_upd(32'h40, 1'b1, 32'h140, 1'b0, 32'h44);
    #1;
    check("same_cycle.before", {31'd0, lk_hit}, 32'd0);
    tick();
    look(32'h40, 1'b1, 1'b1, 32'h140, "same_cycle.after");

    // flush_all beats a simultaneous taken update
    flush_all = 1'b1;
    drive_upd(32'h80, 1'b1, 32'h500, 1'b0, 32'h84);
    tick();
    look(32'h80, 1'b0, 1'b0, 32'h84, "flush_upd.80");
    look(32'h40, 1'b0, 1'b0, 32'h44, "flush_upd.40");
`ifdef BTB_STATS_EN
    check("stat_updates", stat_updates, exp_upd);
    check("stat_lookups", stat_lookups, exp_lk);
    check("stat_mispredicts", stat_mispredicts, exp_mis);
`endif

    // Reset asserted mid-update aborts the write
    upd(32'h40, 1'b1, 32'h140, 1'b0, 32'h44);
    drive_upd(32'h80, 1'b1, 32'h600, 1'b0, 32'h84);
    reset = 1'b0;
    #1;
    check("mid_rst.mispredict", {31'd0, upd_mispredict}, 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    look(32'h40, 1'b0, 1'b0, 32'h44, "mid_rst.40");
    look(32'h80, 1'b0, 1'b0, 32'h84, "mid_rst.80");
`ifdef BTB_STATS_EN
    check("mid_rst.stat_updates", stat_updates, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
